// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
//
// Shares one single-ported 64-bit synchronous memory between the instruction
// fetch requester and the data load/store requester of the multicycle core.
// One access is granted at a time. Reads return after a fixed RD_LAT cycles
// with a one-cycle rvalid pulse to the side that issued them. Stores finish
// at the grant edge.
//
// Parameters
//   RD_LAT     memory read latency, from the issue edge to valid data (1..7)
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous active-high reset
//   i_req      fetch request, held until i_gnt
//   i_addr     fetch byte address
//   i_gnt      fetch accepted this cycle (combinational from the requests)
//   i_rvalid   one-cycle pulse, i_rdata valid
//   i_rdata    fetched 32-bit word (the half of mem_rdata picked by addr[2])
//   d_req      data request, held until d_gnt
//   d_we       1 = store, 0 = load
//   d_addr     data byte address
//   d_wdata    store data
//   d_gnt      data access accepted this cycle
//   d_rvalid   one-cycle pulse, d_rdata valid
//   d_rdata    load data (mem_rdata passed straight through)
//   mem_addr   memory address, driven only in a grant cycle, else 0
//   mem_wdata  memory write data, driven only on a data grant, else 0
//   mem_wr     memory write strobe, one cycle per store grant
//   mem_rdata  memory read data
//   busy       a read is outstanding
// ============================================================================
module mem_port_arbiter #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [63:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    // Encoding shared by the owner and last-granted flags.
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

    state_t     state_q, state_d;
    logic [2:0] cnt_q,   cnt_d;
    logic       own_q,   own_d;
    logic       hsel_q,  hsel_d;
    logic       last_q,  last_d;

    logic       final_cyc;
    logic       arb_en;
    logic       i_win;
    logic       d_win;
    logic       rd_issue;

    // ------------------------------------------------------------------------
    // Arbitration. A new access may be granted while idle, or in the last
    // cycle of an outstanding read because the memory is free again at the
    // following edge. Reset gates the grants so requests held across reset
    // are not accepted until reset is released.
    // ------------------------------------------------------------------------
    always_comb begin
        final_cyc = (state_q == RD_WAIT) && (cnt_q == 3'd1);
        arb_en    = !reset && ((state_q == IDLE) || final_cyc);
        // On contention the side that did not win last time goes first.
        i_win     = arb_en && i_req && (!d_req || (last_q == SIDE_D));
        d_win     = arb_en && d_req && (!i_req || (last_q == SIDE_I));
        rd_issue  = i_win || (d_win && !d_we);
    end

    // ------------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        own_d   = own_q;
        hsel_d  = hsel_q;
        last_d  = last_q;

        // Countdown of the outstanding read; cnt never sits at 0 in RD_WAIT,
        // but treat it like the final cycle so the FSM cannot get stuck.
        if (state_q == RD_WAIT) begin
            if (cnt_q <= 3'd1) begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end else begin
                cnt_d   = cnt_q - 3'd1;
            end
        end

        // A read granted in the final cycle overrides the return to IDLE.
        if (rd_issue) begin
            state_d = RD_WAIT;
            cnt_d   = LAT_LOAD;
            own_d   = i_win ? SIDE_I : SIDE_D;
            if (i_win) begin
                hsel_d = i_addr[2];
            end
        end

        if (i_win) begin
            last_d = SIDE_I;
        end else if (d_win) begin
            last_d = SIDE_D;
        end
    end

    // ------------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            own_q   <= SIDE_I;
            hsel_q  <= 1'b0;
            last_q  <= SIDE_D;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            own_q   <= own_d;
            hsel_q  <= hsel_d;
            last_q  <= last_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. rvalid decodes registered state only, so there is no path
    // from mem_rdata to any grant; the memory latches its address at the
    // issue edge, so mem_addr is released right after the grant.
    // ------------------------------------------------------------------------
    always_comb begin
        i_gnt     = i_win;
        d_gnt     = d_win;
        mem_wr    = d_win && d_we;
        mem_addr  = 64'd0;
        mem_wdata = 64'd0;
        if (i_win) begin
            mem_addr = i_addr;
        end else if (d_win) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
        i_rvalid = final_cyc && (own_q == SIDE_I);
        d_rvalid = final_cyc && (own_q == SIDE_D);
        i_rdata  = hsel_q ? mem_rdata[63:32] : mem_rdata[31:0];
        d_rdata  = mem_rdata;
        busy     = (state_q == RD_WAIT);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
//
// Two arbiter instances (RD_LAT = 2 and RD_LAT = 1) run side by side. Each
// one goes through a directed sequence and then a randomized phase. Every
// cycle, all outputs are compared against a reference model that tracks an
// outstanding read as "due at cycle N, owned by side S".
// ============================================================================
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 2 : 1;

        logic        rst;
        logic        i_req, i_gnt, i_rvalid;
        logic [63:0] i_addr;
        logic [31:0] i_rdata;
        logic        d_req, d_we, d_gnt, d_rvalid;
        logic [63:0] d_addr, d_wdata, d_rdata;
        logic [63:0] mem_addr, mem_wdata, mem_rdata;
        logic        mem_wr, busy;

        mem_port_arbiter #(.RD_LAT(LAT)) u_dut (
            .clk       (clk),
            .reset     (rst),
            .i_req     (i_req),
            .i_addr    (i_addr),
            .i_gnt     (i_gnt),
            .i_rvalid  (i_rvalid),
            .i_rdata   (i_rdata),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_gnt     (d_gnt),
            .d_rvalid  (d_rvalid),
            .d_rdata   (d_rdata),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_wr    (mem_wr),
            .mem_rdata (mem_rdata),
            .busy      (busy)
        );

        // Reference model: at most one read in flight, due at cycle m_due.
        int  cyc;
        bit  m_out;
        int  m_due;
        bit  m_own;     // 1 = data side owns the read
        bit  m_hsel;
        bit  m_last;    // 1 = data side was granted last
        bit  e_ig, e_dg;

        // Observed outputs of the most recent cycle.
        logic        s_ig, s_dg, s_iv, s_dv, s_wr, s_busy;
        logic [63:0] s_addr, s_wdata;
        logic [31:0] s_irdata;

        // One clock cycle: inputs are already set; compare at the falling
        // edge, then advance the model across the rising edge.
        task automatic tick();
            bit          arb, e_iv, e_dv, e_wr, e_busy;
            logic [63:0] e_addr, e_wdata;
            string       p;
            p = $sformatf("L%0d c%0d", LAT, cyc);
            @(negedge clk);
            if (rst) begin
                m_out  = 1'b0;
                m_last = 1'b1;
            end
            arb     = !rst && (!m_out || (m_due == cyc));
            e_ig    = arb && i_req && (!d_req || m_last);
            e_dg    = arb && d_req && (!i_req || !m_last);
            e_iv    = !rst && m_out && (m_due == cyc) && !m_own;
            e_dv    = !rst && m_out && (m_due == cyc) && m_own;
            e_busy  = !rst && m_out;
            e_wr    = e_dg && d_we;
            e_addr  = e_ig ? i_addr : (e_dg ? d_addr : 64'd0);
            e_wdata = e_dg ? d_wdata : 64'd0;

            check_val({p, " i_gnt"},     64'(i_gnt),    64'(e_ig));
            check_val({p, " d_gnt"},     64'(d_gnt),    64'(e_dg));
            check_val({p, " i_rvalid"},  64'(i_rvalid), 64'(e_iv));
            check_val({p, " d_rvalid"},  64'(d_rvalid), 64'(e_dv));
            check_val({p, " mem_wr"},    64'(mem_wr),   64'(e_wr));
            check_val({p, " busy"},      64'(busy),     64'(e_busy));
            check_val({p, " mem_addr"},  mem_addr,      e_addr);
            check_val({p, " mem_wdata"}, mem_wdata,     e_wdata);
            check_val({p, " d_rdata"},   d_rdata,       mem_rdata);
            if (e_iv) begin
                check_val({p, " i_rdata"}, 64'(i_rdata),
                          64'(m_hsel ? mem_rdata[63:32] : mem_rdata[31:0]));
            end

            s_ig = i_gnt;  s_dg = d_gnt;  s_iv = i_rvalid;  s_dv = d_rvalid;
            s_wr = mem_wr; s_busy = busy; s_addr = mem_addr; s_wdata = mem_wdata;
            s_irdata = i_rdata;

            if (!rst) begin
                if (m_out && (m_due == cyc)) m_out = 1'b0;
                if (e_ig || (e_dg && !d_we)) begin
                    m_out = 1'b1;
                    m_due = cyc + LAT;
                    m_own = e_dg;
                    if (e_ig) m_hsel = i_addr[2];
                end
                if (e_ig)      m_last = 1'b0;
                else if (e_dg) m_last = 1'b1;
            end
            @(posedge clk);
            cyc++;
            #1;
        endtask

        // Random requester agents: hold until granted, drop for at least one
        // cycle after a grant, occasionally withdraw, occasionally reset.
        task automatic drive_rand();
            mem_rdata = {$urandom, $urandom};
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 99) == 0) rst = 1'b1;
            if (i_req && (e_ig || $urandom_range(0, 19) == 0)) begin
                i_req = 1'b0;
            end else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req  = 1'b1;
                i_addr = {$urandom, $urandom} & ~64'h3;
            end
            if (d_req && (e_dg || $urandom_range(0, 19) == 0)) begin
                d_req = 1'b0;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = ($urandom_range(0, 2) == 0);
                d_addr  = {$urandom, $urandom} & ~64'h7;
                d_wdata = {$urandom, $urandom};
            end
        endtask

        initial begin
            logic [5:0] order;
            int         ngr, bound, cnt_g, cnt_v;
            bit         seen_iv;
            string      p;
            p = $sformatf("L%0d", LAT);

            cyc = 0; m_out = 0; m_due = 0; m_own = 0; m_hsel = 0; m_last = 1;
            e_ig = 0; e_dg = 0;

            // Reset, then a single fetch at 0x104 (upper word selected).
            rst = 1; i_req = 1; i_addr = 64'h104;
            d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
            mem_rdata = {$urandom, $urandom};
            tick();
            check_val({p, " reset i_gnt"}, 64'(s_ig), 64'd0);
            check_val({p, " reset busy"},  64'(s_busy), 64'd0);
            tick();
            rst = 0;
            tick();
            check_val({p, " fetch gnt"},  64'(s_ig), 64'd1);
            check_val({p, " fetch addr"}, s_addr, 64'h104);
            i_req = 0;
            repeat (LAT - 1) tick();
            mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
            tick();
            check_val({p, " fetch rvalid"}, 64'(s_iv), 64'd1);
            check_val({p, " fetch rdata"},  64'(s_irdata), 64'hAAAABBBB);

            // Simultaneous fetch and load straight out of reset.
            rst = 1; tick(); rst = 0;
            i_req = 1; i_addr = 64'h200; d_req = 1; d_we = 0; d_addr = 64'h300;
            mem_rdata = {$urandom, $urandom};
            tick();
            check_val({p, " both first i_gnt"}, 64'(s_ig), 64'd1);
            check_val({p, " both first d_gnt"}, 64'(s_dg), 64'd0);
            i_req = 0;
            repeat (LAT - 1) tick();
            tick();
            check_val({p, " both i_rvalid"}, 64'(s_iv), 64'd1);
            check_val({p, " both d_gnt"},    64'(s_dg), 64'd1);
            check_val({p, " both d_addr"},   s_addr, 64'h300);
            d_req = 0;
            repeat (LAT - 1) tick();
            tick();
            check_val({p, " both d_rvalid"}, 64'(s_dv), 64'd1);

            // Store while idle.
            d_req = 1; d_we = 1; d_addr = 64'h40; d_wdata = 64'h1234;
            tick();
            check_val({p, " st gnt"},   64'(s_dg), 64'd1);
            check_val({p, " st wr"},    64'(s_wr), 64'd1);
            check_val({p, " st addr"},  s_addr, 64'h40);
            check_val({p, " st wdata"}, s_wdata, 64'h1234);
            d_req = 0; d_we = 0;
            tick();
            check_val({p, " st wr after"}, 64'(s_wr), 64'd0);
            check_val({p, " st busy"},     64'(s_busy), 64'd0);
            check_val({p, " st rvalid"},   64'(s_dv), 64'd0);

            // Round robin with both sides requesting continuously.
            order = 0; ngr = 0; bound = 0;
            i_req = 1; i_addr = 64'h500; d_req = 1; d_we = 0; d_addr = 64'h600;
            while (ngr < 6 && bound < 40) begin
                tick();
                bound++;
                if (s_ig || s_dg) begin
                    order = {order[4:0], s_dg};
                    ngr++;
                end
                i_req = !s_ig;
                d_req = !s_dg;
            end
            check_val({p, " rr grants"}, 64'(ngr), 64'd6);
            check_val({p, " rr order"},  64'(order), 64'h15);
            i_req = 0; d_req = 0;
            repeat (LAT) tick();

            // Reset in the cycle after a fetch grant.
            i_req = 1; i_addr = 64'h108;
            tick();
            check_val({p, " mid gnt"}, 64'(s_ig), 64'd1);
            i_req = 0; rst = 1;
            tick();
            check_val({p, " mid busy"}, 64'(s_busy), 64'd0);
            seen_iv = s_iv;
            rst = 0;
            repeat (LAT + 1) begin
                tick();
                seen_iv |= s_iv;
            end
            check_val({p, " mid no rvalid"}, 64'(seen_iv), 64'd0);
            i_req = 1; i_addr = 64'h10C;
            tick();
            check_val({p, " post gnt"}, 64'(s_ig), 64'd1);
            i_req = 0;
            repeat (LAT - 1) tick();
            tick();
            check_val({p, " post rvalid"}, 64'(s_iv), 64'd1);

            // Streaming loads with a one-cycle gap after each grant.
            cnt_g = 0; cnt_v = 0;
            d_req = 1; d_we = 0; d_addr = {$urandom, $urandom} & ~64'h7;
            repeat (20) begin
                mem_rdata = {$urandom, $urandom};
                tick();
                cnt_g += int'(s_dg);
                cnt_v += int'(s_dv);
                if (s_dg) begin
                    d_req = 0;
                end else if (!d_req) begin
                    d_req  = 1;
                    d_addr = {$urandom, $urandom} & ~64'h7;
                end
            end
            d_req = 0;
            repeat (LAT) begin
                mem_rdata = {$urandom, $urandom};
                tick();
                cnt_v += int'(s_dv);
            end
            check_val({p, " stream grants"}, 64'(cnt_g), 64'd10);
            check_val({p, " stream rvalids"}, 64'(cnt_v), 64'd10);

            // Randomized traffic.
            repeat (3000) begin
                drive_rand();
                tick();
            end
            n_done++;
        end
    end

    initial begin
        fork
            wait (n_done == 2);
            begin
                #500_000;
                check_val("timeout", 64'(n_done), 64'd2);
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported 64-bit synchronous memory between the instruction-fetch requester and the data load/store requester of the multicycle RISC-V core. It sits between the control unit and the PC/ALUOut address paths on one side, and the memory macro on the other. It grants one access at a time and drives the memory address, data and write strobe. It returns read data with a fixed, parameterised latency and a valid pulse, so the control unit can stall in its fetch and memory-access states.

## Interface
- RD_LAT, 2, memory read latency in cycles from the issue edge to valid data; legal range 1..7
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- i_req  in  1  instruction fetch request; held high until i_gnt
- i_addr  in  64  fetch byte address; stable while i_req is high
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  one-cycle pulse; i_rdata is valid this cycle
- i_rdata  out  32  fetched instruction word
- d_req  in  1  data request; held high until d_gnt
- d_we  in  1  1 = store, 0 = load; stable while d_req is high
- d_addr  in  64  data byte address
- d_wdata  in  64  store data
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  one-cycle pulse; d_rdata is valid this cycle
- d_rdata  out  64  load data, passed through from mem_rdata
- mem_addr  out  64  memory address (read and write)
- mem_wdata  out  64  memory write data
- mem_wr  out  1  memory write strobe
- mem_rdata  in  64  memory read data
- busy  out  1  a read is outstanding

## Operation
- **FSM states**
  - IDLE: no read outstanding.
  - RD_WAIT: a read has issued; the countdown counter `cnt` (3 bits) is running.
- **Arbitration**
  - Arbitration is evaluated combinationally in IDLE, and in the final RD_WAIT cycle (the cycle with cnt==1).
  - Only one requester high: it wins.
  - Both high: round-robin. The side not granted last wins.
  - The `last` flag resets to DATA, so the first contested grant goes to fetch.
  - `last` updates only on a grant.
- **Grant cycle**
  - Exactly one of i_gnt or d_gnt is 1.
  - mem_addr is driven from the winner's address.
  - On a data grant, mem_wdata = d_wdata.
- **Stores**
  - On a store grant (d_gnt & d_we), mem_wr = 1 for that cycle only.
  - The store completes at the grant edge.
  - No d_rvalid is produced, and the FSM stays in or returns to IDLE.
- **Loads and fetches**
  - The grant loads cnt = RD_LAT and moves the FSM to RD_WAIT.
  - The arbiter records which side owns the read (`own`) and captures i_addr[2] (`hsel`).
  - cnt decrements every cycle.
  - In the cycle cnt==1, the owner's rvalid is 1.
  - The FSM leaves RD_WAIT at the end of that cycle, unless a new read is granted in the same cycle, in which case cnt reloads.
- **Fetch data**
  - i_rdata = mem_rdata[63:32] when hsel = 1, else mem_rdata[31:0].
  - The memory captures the address at the issue edge, so mem_addr is free after the grant.
- **Idle outputs**
  - When there is no grant, mem_addr = 0, mem_wdata = 0 and mem_wr = 0.
- **busy** is 1 in RD_WAIT.
- **Request withdrawal**
  - A request dropped before its grant is legal and produces no access.
  - A request raised while busy waits, and is not granted, until the final RD_WAIT cycle.
- **Reset** (asynchronous, any time, including mid-read)
  - Forces IDLE, cnt = 0, last = DATA.
  - Any pending rvalid is discarded and never asserted.
  - Requests present during reset are not granted until after reset deasserts.
- **Reset output values:** i_gnt, d_gnt, i_rvalid, d_rvalid, mem_wr and busy are all 0; mem_addr and mem_wdata are 0; i_rdata and d_rdata follow mem_rdata.

## Timing
- Grant latency: 0 cycles. The gnt is combinational from req in the same cycle, with no combinational path from rdata.
- Read latency: rvalid asserts exactly RD_LAT cycles after the grant cycle.
  - RD_LAT = 1: rvalid is in the cycle immediately after the grant.
- Read throughput: back-to-back reads issue every RD_LAT cycles. The next grant may coincide with the previous read's rvalid cycle.
- Stores: one per cycle while in IDLE with no outstanding read. A store request arriving in the final RD_WAIT cycle may be granted in that cycle.
- A requester must not raise a new request in the same cycle as its own gnt. Its next request starts on the following cycle at the earliest.
- Registered state: state, cnt, own, hsel, last. All are cleared asynchronously on reset.

## Test plan
- **Reset, then a single fetch.** RD_LAT = 2; i_req = 1, i_addr = 0x104.
  - Required: i_gnt = 1 at cycle 0; mem_addr = 0x104.
  - With mem_rdata = 0xAAAA_BBBB_CCCC_DDDD at cycle 2: i_rvalid = 1 at cycle 2, and i_rdata = 0xAAAABBBB because addr[2] = 1.
- **Simultaneous requests from reset.** i_req and d_req both high, load.
  - Required: i_gnt is granted first.
  - d_gnt follows in the cycle i_rvalid asserts; d_rvalid follows 2 cycles later.
- **Store while idle.** d_we = 1, d_addr = 0x40, d_wdata = 0x1234.
  - Required: d_gnt = mem_wr = 1 for exactly 1 cycle; mem_addr = 0x40; mem_wdata = 0x1234.
  - No d_rvalid; busy stays 0.
- **Round-robin fairness.** Both sides request continuously for 6 grants.
  - Required: grant order I, D, I, D, I, D.
  - No requester waits longer than RD_LAT cycles after the other side's grant.
- **Reset mid-read.** Fetch granted, then reset pulsed 1 cycle later.
  - Required: i_rvalid never asserts; busy = 0 immediately.
  - A new fetch after reset is granted with normal latency.
- **RD_LAT = 1 streaming.** d_req held with loads and a new address each cycle after gnt.
  - Required: d_gnt on every other cycle at most (the requester's one-cycle gap).
  - d_rvalid is 1 cycle after each grant, with correct d_rdata.
